// File: rtl/ve32_pkg.sv
// Shared parameters and state type for the ve32 column carry-resolve stage.
// Widths are sized for four 8-bit chunks feeding seven column sums.
package ve32_pkg;

    localparam int CHUNK_W = 8;
    localparam int NCOL    = 7;
    localparam int COL_W   = 18;
    localparam int CARRY_W = 11;
    localparam int PROD_W  = CHUNK_W * (NCOL + 1);
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ve32_column_combiner.sv
// Sequential carry-resolve stage: ripples the carry through one column sum per
// cycle and presents the 64-bit product behind a valid/ready handshake.
module ve32_column_combiner
    import ve32_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCOL*COL_W-1:0]    cols,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PROD_W-1:0]        prod,
    output logic                     ovf,
    output logic                     busy
);

    state_e               state_q, state_d;
    logic [COL_W-1:0]     col_q [NCOL];
    logic [COL_W-1:0]     col_d [NCOL];
    logic [CARRY_W-1:0]   carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PROD_W-1:0]    prod_q, prod_d;
    logic                 ovf_q, ovf_d;
    logic [COL_W:0]       step_sum;

    // One column plus the running carry; the extra bit keeps the full carry-out.
    assign step_sum = {1'b0, col_q[cnt_q]}
                    + {{(COL_W + 1 - CARRY_W){1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < NCOL; k++) begin
                        col_d[k] = cols[k*COL_W +: COL_W];
                    end
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NCOL; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        prod_d[k*CHUNK_W +: CHUNK_W] = step_sum[CHUNK_W-1:0];
                    end
                end
                carry_d = step_sum[COL_W:CHUNK_W];
                if (cnt_q == CNT_W'(NCOL - 1)) begin
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                // Whatever carry remains above the top byte means the columns were illegal.
                prod_d[PROD_W-1 -: CHUNK_W] = carry_q[CHUNK_W-1:0];
                ovf_d   = |carry_q[CARRY_W-1:CHUNK_W];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int k = 0; k < NCOL; k++) begin
                col_q[k] <= '0;
            end
            carry_q <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == FLUSH);
    assign prod      = prod_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ve32_column_combiner.sv
// Self-checking bench for ve32_column_combiner: directed corner cases plus
// random a*b products checked against a plain-arithmetic reference.
module tb_ve32_column_combiner;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [125:0] cols;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  prod;
    logic         ovf;
    logic         busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    ve32_column_combiner dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cols      (cols),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: weighted sum of all columns, wide enough to keep the overflow.
    function automatic logic [71:0] ref_total(input logic [125:0] v);
        logic [71:0] t;
        logic [71:0] c;
        t = '0;
        for (int k = 0; k < 7; k++) begin
            c = 72'(v[k*18 +: 18]);
            t = t + (c << (8 * k));
        end
        return t;
    endfunction

    // Column sums a 32x32 crosswise generator would hand us for a and b.
    function automatic logic [125:0] cols_from_ab(input logic [31:0] a, input logic [31:0] b);
        logic [17:0]  c [7];
        logic [17:0]  pa, pb;
        logic [125:0] v;
        for (int k = 0; k < 7; k++) c[k] = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pa = 18'(a[8*i +: 8]);
                pb = 18'(b[8*j +: 8]);
                c[i+j] = c[i+j] + pa * pb;
            end
        end
        for (int k = 0; k < 7; k++) v[k*18 +: 18] = c[k];
        return v;
    endfunction

    function automatic logic [125:0] pack7(input logic [17:0] c0, input logic [17:0] c1,
                                           input logic [17:0] c2, input logic [17:0] c3,
                                           input logic [17:0] c4, input logic [17:0] c5,
                                           input logic [17:0] c6);
        return {c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // Drives one bundle and waits for its result; lat counts edges from accept to valid.
    task automatic run_bundle(input logic [125:0] v, input bit ack,
                              output logic [63:0] p, output logic o,
                              output int lat, output int busyc, output bit to);
        int n;
        int acc;
        to = 1'b0; lat = -1; busyc = 0; p = '0; o = 1'b0;
        @(negedge clk);
        cols = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        cols = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!out_valid && n < 50) begin
            if (busy) busyc++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        lat = cyc - acc;
        p = prod;
        o = ovf;
        if (ack) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cols = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, ovf, prod} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'h0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b busy=%b ovf=%b prod=%h expected 1 0 0 0 0",
                     in_ready, out_valid, busy, ovf, prod);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max();
        logic [125:0] v;
        logic [63:0]  p;
        logic         o;
        int           lat, bc;
        bit           to;
        v = pack7(18'd65025, 18'd130050, 18'd195075, 18'd260100, 18'd195075, 18'd130050, 18'd65025);
        run_bundle(v, 1'b1, p, o, lat, bc, to);
        checks++;
        if (to !== 1'b0) begin
            failures++;
            $display("[TB] FAIL max_timeout: got timeout=%b expected 0", to);
        end
        checks++;
        if ({o, p} !== {1'b0, 64'hFFFFFFFE00000001}) begin
            failures++;
            $display("[TB] FAIL max_prod: got ovf=%b prod=%h expected ovf=0 prod=fffffffe00000001", o, p);
        end
        // out_valid first visible after edge T+8, so it is high at edge T+9.
        checks++;
        if (lat != 8) begin
            failures++;
            $display("[TB] FAIL max_latency: got %0d expected 8", lat);
        end
        checks++;
        if (bc != 8) begin
            failures++;
            $display("[TB] FAIL max_busy_cycles: got %0d expected 8", bc);
        end
    endtask

    task automatic test_simple();
        logic [125:0] v;
        logic [63:0]  p;
        logic         o;
        int           lat, bc;
        bit           to;
        v = pack7(18'h78, 18'h56, 18'h34, 18'h12, 18'h0, 18'h0, 18'h0);
        run_bundle(v, 1'b1, p, o, lat, bc, to);
        checks++;
        if ({to, o, p} !== {1'b0, 1'b0, 64'h0000000012345678}) begin
            failures++;
            $display("[TB] FAIL simple_prod: got to=%b ovf=%b prod=%h expected 0 0 0000000012345678", to, o, p);
        end
    endtask

    task automatic test_ovf();
        logic [125:0] v;
        logic [71:0]  t;
        logic [63:0]  p;
        logic         o;
        int           lat, bc;
        bit           to;
        v = {7{18'h3FFFF}};
        t = ref_total(v);
        run_bundle(v, 1'b1, p, o, lat, bc, to);
        checks++;
        if ({to, o, p} !== {1'b0, |t[71:64], t[63:0]}) begin
            failures++;
            $display("[TB] FAIL ovf_all_ones: got to=%b ovf=%b prod=%h expected 0 %b %h", to, o, p, |t[71:64], t[63:0]);
        end
        checks++;
        if (o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_flag: got %b expected 1", o);
        end
    endtask

    task automatic test_stall();
        logic [31:0]  a, b;
        logic [63:0]  exp, pa, pb, p;
        logic         o;
        int           lat, bc;
        bit           to;
        a = $urandom; b = $urandom;
        pa = 64'(a); pb = 64'(b);
        exp = pa * pb;
        run_bundle(cols_from_ab(a, b), 1'b0, p, o, lat, bc, to);
        checks++;
        if ({to, o, p} !== {1'b0, 1'b0, exp}) begin
            failures++;
            $display("[TB] FAIL stall_first: got to=%b ovf=%b prod=%h expected 0 0 %h", to, o, p, exp);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            cols = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, busy, ovf, prod} !== {1'b1, 1'b0, 1'b0, 1'b0, exp}) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d]: got vld=%b rdy=%b busy=%b ovf=%b prod=%h expected 1 0 0 0 %h",
                         i, out_valid, in_ready, busy, ovf, prod, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL stall_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] p;
        logic        o;
        int          lat, bc;
        bit          to;
        @(negedge clk);
        cols = {7{18'h3FFFF}};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrun_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL midrun_reset: got vld=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_bundle(pack7(18'd1, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0), 1'b0, p, o, lat, bc, to);
        checks++;
        if ({to, o, p} !== {1'b0, 1'b0, 64'd1}) begin
            failures++;
            $display("[TB] FAIL after_reset_prod: got to=%b ovf=%b prod=%h expected 0 0 1", to, o, p);
        end
        // Result is now pending in DONE; reset must drop out_valid without a clock.
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL done_reset: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0]  a, b;
        logic [63:0]  exp, pa, pb, p;
        logic [125:0] v;
        logic [71:0]  t;
        logic         o;
        int           lat, bc;
        bit           to;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            pa = 64'(a); pb = 64'(b);
            exp = pa * pb;
            run_bundle(cols_from_ab(a, b), 1'b1, p, o, lat, bc, to);
            checks++;
            if ({to, o, p} !== {1'b0, 1'b0, exp}) begin
                failures++;
                $display("[TB] FAIL random_ab[%0d]: a=%h b=%h got to=%b ovf=%b prod=%h expected 0 0 %h",
                         i, a, b, to, o, p, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 7; k++) v[k*18 +: 18] = 18'($urandom_range(200000, 262143));
            t = ref_total(v);
            run_bundle(v, 1'b1, p, o, lat, bc, to);
            checks++;
            if ({to, o, p} !== {1'b0, |t[71:64], t[63:0]}) begin
                failures++;
                $display("[TB] FAIL random_illegal[%0d]: got to=%b ovf=%b prod=%h expected 0 %b %h",
                         i, to, o, p, |t[71:64], t[63:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [125:0] bun [3];
        logic [63:0]  exp [3];
        logic [63:0]  pa, pb;
        logic [31:0]  a, b;
        int           acc [3];
        int           nacc, nout, n;
        bit           upd;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            pa = 64'(a); pb = 64'(b);
            exp[i] = pa * pb;
            bun[i] = cols_from_ab(a, b);
            acc[i] = 0;
        end
        nacc = 0; nout = 0; n = 0; upd = 1'b0;
        @(negedge clk);
        cols = bun[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (nout < 3 && n < 200) begin
            if (upd) begin
                upd = 1'b0;
                if (nacc < 3) cols = bun[nacc];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                checks++;
                if ({ovf, prod} !== {1'b0, exp[nout]}) begin
                    failures++;
                    $display("[TB] FAIL b2b_prod[%0d]: got ovf=%b prod=%h expected 0 %h", nout, ovf, prod, exp[nout]);
                end
                nout++;
            end
            if (in_valid && in_ready && nacc < 3) begin
                acc[nacc] = cyc + 1;
                nacc++;
                upd = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nout != 3) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d results expected 3", nout);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 10) begin
                failures++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected 10", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_simple();
        test_ovf();
        test_stall();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
